// File: rtl/alarm_ring.sv
// rtl/alarm_ring.sv - alarm match detector with ring/snooze/stop state machine and gated buzzer tone
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   sec_en        one-clk pulse per second
//   hour_reg      current hour
//   min_reg       current minute
//   hour_clock    alarm hour
//   min_clock     alarm minute
//   alarm_on      alarm enable level
//   stop_key      one-clk pulse, stop ringing
//   snooze_key    one-clk pulse, snooze
//   buzzer        registered tone output
//   ring_active   high while ringing
//   snooze_active high while snoozing
//   snooze_cnt    snoozes used in the current alarm event

module alarm_ring #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int TONE_HALF      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_en,
    input  logic [7:0] hour_reg,
    input  logic [7:0] min_reg,
    input  logic [7:0] hour_clock,
    input  logic [7:0] min_clock,
    input  logic       alarm_on,
    input  logic       stop_key,
    input  logic       snooze_key,
    output logic       buzzer,
    output logic       ring_active,
    output logic       snooze_active,
    output logic [1:0] snooze_cnt
);

    localparam int SEC_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
    localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_SECONDS - 1);
    localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SECONDS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(TONE_HALF - 1);
    localparam logic [1:0]        SNZ_MAX     = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SEC_W-1:0]   sec_cnt, sec_cnt_n;
    logic [TONE_W-1:0]  tone_cnt, tone_cnt_n;
    logic               tone, tone_n;
    logic               beep_phase, beep_phase_n;
    logic [1:0]         snooze_cnt_n;
    logic               match_d;
    logic               match_now;
    logic               trigger;

    // Only a rising edge of the match starts a ring, so a match that
    // persists for the whole minute rings once.
    assign match_now = (hour_reg == hour_clock) && (min_reg == min_clock);
    assign trigger   = match_now & ~match_d & alarm_on;

    always_comb begin
        state_n      = state;
        sec_cnt_n    = sec_cnt;
        tone_cnt_n   = tone_cnt;
        tone_n       = tone;
        beep_phase_n = beep_phase;
        snooze_cnt_n = snooze_cnt;

        if (state == ST_RING) begin
            if (tone_cnt == TONE_LAST) begin
                tone_cnt_n = '0;
                tone_n     = ~tone;
            end else begin
                tone_cnt_n = tone_cnt + TONE_W'(1);
            end
        end

        if (!alarm_on) begin
            state_n      = ST_IDLE;
            snooze_cnt_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state_n      = ST_RING;
                        sec_cnt_n    = '0;
                        beep_phase_n = 1'b1;
                        tone_cnt_n   = '0;
                        snooze_cnt_n = '0;
                    end
                end
                ST_RING: begin
                    // Keys outrank the timeout; stop outranks snooze.
                    if (stop_key) begin
                        state_n      = ST_IDLE;
                        snooze_cnt_n = '0;
                    end else if (snooze_key) begin
                        if (snooze_cnt < SNZ_MAX) begin
                            state_n      = ST_SNOOZE;
                            sec_cnt_n    = '0;
                            snooze_cnt_n = snooze_cnt + 2'd1;
                        end else begin
                            state_n      = ST_IDLE;
                            snooze_cnt_n = '0;
                        end
                    end else if (sec_en) begin
                        if (sec_cnt == RING_LAST) begin
                            state_n      = ST_IDLE;
                            snooze_cnt_n = '0;
                        end else begin
                            sec_cnt_n    = sec_cnt + SEC_W'(1);
                            beep_phase_n = ~beep_phase;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_key) begin
                        state_n      = ST_IDLE;
                        snooze_cnt_n = '0;
                    end else if (sec_en) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            state_n      = ST_RING;
                            sec_cnt_n    = '0;
                            beep_phase_n = 1'b1;
                            tone_cnt_n   = '0;
                        end else begin
                            sec_cnt_n = sec_cnt + SEC_W'(1);
                        end
                    end
                end
                default: begin
                    state_n      = ST_IDLE;
                    snooze_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sec_cnt       <= '0;
            tone_cnt      <= '0;
            tone          <= 1'b0;
            beep_phase    <= 1'b0;
            snooze_cnt    <= '0;
            // Starts high so that a reset while time and alarm both read
            // 00:00 does not look like a fresh match.
            match_d       <= 1'b1;
            buzzer        <= 1'b0;
            ring_active   <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            state         <= state_n;
            sec_cnt       <= sec_cnt_n;
            tone_cnt      <= tone_cnt_n;
            tone          <= tone_n;
            beep_phase    <= beep_phase_n;
            snooze_cnt    <= snooze_cnt_n;
            match_d       <= match_now;
            buzzer        <= (state == ST_RING) & beep_phase & tone;
            ring_active   <= (state_n == ST_RING);
            snooze_active <= (state_n == ST_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ring.sv
// tb/tb_alarm_ring.sv - self-checking scoreboard bench for alarm_ring

module tb_alarm_ring;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_en;
    logic [7:0] hour_reg, min_reg, hour_clock, min_clock;
    logic       alarm_on, stop_key, snooze_key;
    logic       buzzer, ring_active, snooze_active;
    logic [1:0] snooze_cnt;

    always #5 clk = ~clk;

    alarm_ring dut (
        .clk           (clk),
        .reset         (reset),
        .sec_en        (sec_en),
        .hour_reg      (hour_reg),
        .min_reg       (min_reg),
        .hour_clock    (hour_clock),
        .min_clock     (min_clock),
        .alarm_on      (alarm_on),
        .stop_key      (stop_key),
        .snooze_key    (snooze_key),
        .buzzer        (buzzer),
        .ring_active   (ring_active),
        .snooze_active (snooze_active),
        .snooze_cnt    (snooze_cnt)
    );

    localparam int SEL_RING = 0, SEL_SNZ = 1, SEL_CNT = 2, SEL_BUZ = 3;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_RING: return int'(ring_active);
            SEL_SNZ:  return int'(snooze_active);
            SEL_CNT:  return int'(snooze_cnt);
            default:  return int'(buzzer);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sec_pulse();
        sec_en = 1'b1;
        tick();
        sec_en = 1'b0;
        tick();
    endtask

    task automatic press(input logic stp, input logic snz, input logic sec);
        stop_key   = stp;
        snooze_key = snz;
        sec_en     = sec;
        tick();
        stop_key   = 1'b0;
        snooze_key = 1'b0;
        sec_en     = 1'b0;
    endtask

    // Produces a fresh rising edge of the 07:30 match.
    task automatic arm_ring(input string tag);
        min_reg = 8'd29;
        tick();
        tick();
        min_reg = 8'd30;
        expect_out(tag, SEL_RING, 1);
        expect_out({tag, "_snz"}, SEL_SNZ, 0);
        tick();
        score();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int any;
        int ok;
        int toggles;
        int ones;
        logic b[24];

        reset = 1'b1;
        sec_en = 0; stop_key = 0; snooze_key = 0;
        hour_reg = 0; min_reg = 0; hour_clock = 0; min_clock = 0;
        alarm_on = 1'b1;
        repeat (3) tick();
        expect_out("rst_ring", SEL_RING, 0);
        expect_out("rst_snz",  SEL_SNZ,  0);
        expect_out("rst_cnt",  SEL_CNT,  0);
        expect_out("rst_buz",  SEL_BUZ,  0);
        score();

        reset = 1'b0;
        any = 0;
        repeat (100) begin
            tick();
            any |= int'(buzzer | ring_active | snooze_active);
        end
        check_eq("no_ring_after_reset", any, 0);

        hour_clock = 8'd7; min_clock = 8'd30; hour_reg = 8'd7; min_reg = 8'd29;
        tick();
        tick();
        arm_ring("ring_start");

        repeat (6) tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            b[i] = buzzer;
        end
        ok = 1;
        for (int i = 4; i < 24; i++)
            if (b[i] == b[i-4]) ok = 0;
        toggles = 0;
        for (int i = 1; i <= 20; i++)
            if (b[i] != b[i-1]) toggles++;
        check_eq("tone_period4", ok, 1);
        check_eq("tone_toggles", toggles, 5);

        sec_pulse();
        repeat (2) tick();
        ones = 0;
        repeat (16) begin
            tick();
            ones += int'(buzzer);
        end
        check_eq("beep_off_second", ones, 0);

        repeat (58) sec_pulse();
        expect_out("ring_at_59s", SEL_RING, 1);
        score();
        sec_pulse();
        expect_out("auto_stop", SEL_RING, 0);
        expect_out("auto_stop_cnt", SEL_CNT, 0);
        score();
        any = 0;
        repeat (20) begin
            tick();
            any |= int'(ring_active);
        end
        check_eq("no_retrigger", any, 0);

        arm_ring("ring_for_snooze");
        for (int s = 1; s <= 3; s++) begin
            press(1'b0, 1'b1, 1'b0);
            expect_out("snooze_enter", SEL_SNZ, 1);
            expect_out("snooze_ring_off", SEL_RING, 0);
            expect_out("snooze_count", SEL_CNT, s);
            score();
            tick();
            tick();
            expect_out("snooze_buz", SEL_BUZ, 0);
            score();
            repeat (299) sec_pulse();
            expect_out("snooze_299s", SEL_SNZ, 1);
            score();
            sec_pulse();
            expect_out("snooze_rering", SEL_RING, 1);
            expect_out("snooze_rering_snz", SEL_SNZ, 0);
            expect_out("snooze_rering_cnt", SEL_CNT, s);
            score();
        end
        press(1'b0, 1'b1, 1'b0);
        expect_out("snooze_over_max_ring", SEL_RING, 0);
        expect_out("snooze_over_max_snz", SEL_SNZ, 0);
        expect_out("snooze_over_max_cnt", SEL_CNT, 0);
        score();

        arm_ring("ring_for_both");
        press(1'b1, 1'b1, 1'b0);
        expect_out("stop_snooze_ring", SEL_RING, 0);
        expect_out("stop_snooze_snz", SEL_SNZ, 0);
        expect_out("stop_snooze_cnt", SEL_CNT, 0);
        score();

        arm_ring("ring_for_stop_timeout");
        repeat (59) sec_pulse();
        press(1'b1, 1'b0, 1'b1);
        expect_out("stop_timeout_ring", SEL_RING, 0);
        expect_out("stop_timeout_snz", SEL_SNZ, 0);
        score();

        arm_ring("ring_for_snz_timeout");
        repeat (59) sec_pulse();
        press(1'b0, 1'b1, 1'b1);
        expect_out("snz_beats_timeout", SEL_SNZ, 1);
        expect_out("snz_beats_timeout_cnt", SEL_CNT, 1);
        score();

        tick();
        alarm_on = 1'b0;
        tick();
        expect_out("alarm_off_snz", SEL_SNZ, 0);
        expect_out("alarm_off_ring", SEL_RING, 0);
        expect_out("alarm_off_cnt", SEL_CNT, 0);
        score();

        min_reg = 8'd29;
        tick();
        tick();
        min_reg = 8'd30;
        tick();
        tick();
        expect_out("no_ring_disabled", SEL_RING, 0);
        score();
        alarm_on = 1'b1;
        repeat (5) tick();
        expect_out("no_ring_late_enable", SEL_RING, 0);
        score();

        arm_ring("ring_for_reset");
        press(1'b0, 1'b1, 1'b0);
        repeat (300) sec_pulse();
        expect_out("pre_reset_cnt", SEL_CNT, 1);
        score();
        for (int k = 0; k < 40 && buzzer !== 1'b1; k++) tick();
        check_eq("buzzer_hi_wait", int'(buzzer), 1);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_rst_buz", SEL_BUZ, 0);
        expect_out("async_rst_ring", SEL_RING, 0);
        expect_out("async_rst_cnt", SEL_CNT, 0);
        score();
        tick();
        reset = 1'b0;
        any = 0;
        repeat (20) begin
            tick();
            any |= int'(ring_active | buzzer);
        end
        check_eq("no_ring_after_mid_reset", any, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
